shift_seq_8bit: RTL and testbench

SHIFT_SEQ_8BIT -- requirements
Module: shift_seq_8bit

---
 rtl/shift_seq_8bit_pkg.sv | 14 +
 rtl/shift_seq_8bit_if.sv | 34 +++
 rtl/shift_seq_8bit_shift.sv | 16 +
 rtl/shift_seq_8bit.sv | 92 +++++++++
 tb/tb_shift_seq_8bit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/shift_seq_8bit_pkg.sv
// Shared definitions for the shift_seq_8bit block.
// Provides the FSM state encoding, the data width and the shift-count width.
package shift_seq_8bit_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_seq_8bit_pkg

// File: rtl/shift_seq_8bit_if.sv
// Request/result bundle for shift_seq_8bit.
// Signals:
//   start - request to begin an operation
//   a     - operand
//   lr    - direction (1 = left, 0 = right)
//   n     - number of 1-bit shifts
//   y     - working/result register
//   busy  - shifting in progress
//   done  - one-cycle pulse, y holds the final result
// master drives the request side; slave is the shifter.
interface shift_seq_8bit_if #(
    parameter int unsigned N_W = 3
);
    import shift_seq_8bit_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a;
    logic              lr;
    logic [N_W-1:0]    n;
    logic [DATA_W-1:0] y;
    logic              busy;
    logic              done;

    modport master (
        output start, a, lr, n,
        input  y, busy, done
    );

    modport slave (
        input  start, a, lr, n,
        output y, busy, done
    );

endinterface : shift_seq_8bit_if

// File: rtl/shift_seq_8bit_shift.sv
// Combinational single-step shifter with zero fill.
// Ports:
//   a  - input value
//   lr - direction (1 = left, 0 = right)
//   y  - a shifted by one position
module shift_8bit
    import shift_seq_8bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic              lr,
    output logic [DATA_W-1:0] y
);

    assign y = lr ? {a[DATA_W-2:0], 1'b0} : {1'b0, a[DATA_W-1:1]};

endmodule : shift_8bit

// File: rtl/shift_seq_8bit.sv
// Sequential shifter: captures an operand, direction and count on an
// accepted start, then shifts one bit per clock until the count runs out.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - request/result bundle (slave side)
module shift_seq_8bit
    import shift_seq_8bit_pkg::*;
#(
    parameter int unsigned N_W = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    shift_seq_8bit_if.slave    bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] w_y_nxt;
    logic [N_W-1:0]    r_cnt;
    logic [N_W-1:0]    w_cnt_nxt;
    logic              r_lr;
    logic              w_lr_nxt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] w_shift_y;

    // One-bit datapath step on the working register
    shift_8bit u_shift (
        .a  (r_y),
        .lr (r_lr),
        .y  (w_shift_y)
    );

    // Next-state and datapath-next logic
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_cnt_nxt   = r_cnt;
        w_lr_nxt    = r_lr;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_y_nxt     = bus.a;
                    w_lr_nxt    = bus.lr;
                    w_cnt_nxt   = bus.n;
                    w_state_nxt = (bus.n != '0) ? SHIFT : DONE;
                end else if (r_state == DONE) begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_y_nxt   = w_shift_y;
                w_cnt_nxt = r_cnt - N_W'(1);
                // Last step lands the result; DONE marks it valid
                if (r_cnt == N_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_cnt   <= '0;
            r_lr    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lr    <= w_lr_nxt;
            // Flags track the state being entered so they mirror it exactly
            r_busy  <= (w_state_nxt == SHIFT);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign bus.y    = r_y;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule : shift_seq_8bit

// File: tb/tb_shift_seq_8bit.sv
// Self-checking bench for shift_seq_8bit: directed scenarios plus random
// operations compared against an arithmetic reference (a << j / a >> j).
module tb_shift_seq_8bit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shift_seq_8bit_if #(.N_W(3)) bus ();

    shift_seq_8bit #(.N_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected working register j shift steps after loading a
    function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic lr, input int j);
        logic [7:0] r;
        r = lr ? (a << j) : (a >> j);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check busy/done exclusivity on the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        assert (!(bus.busy === 1'b1 && bus.done === 1'b1)) else begin
            errors++;
            $error("FAIL busy_done_excl observed=%b%b expected=not 11", bus.busy, bus.done);
        end
    endtask

    task automatic idle_hold(input logic [7:0] yexp);
        tick();
        chk("idle_y", bus.y, yexp);
        chk("idle_busy", 8'(bus.busy), 8'h00);
        chk("idle_done", 8'(bus.done), 8'h00);
    endtask

    // One operation; optional spurious start at step intr_j, optional reset at step rst_j
    task automatic run_op(input logic [7:0] a, input logic lr, input int n,
                          input int intr_j, input int rst_j);
        bus.start = 1'b1;
        bus.a     = a;
        bus.lr    = lr;
        bus.n     = 3'(n);
        tick();
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.lr    = 1'($urandom);
        bus.n     = 3'($urandom);
        for (int j = 0; j <= n; j++) begin
            chk("op_y", bus.y, ref_shift(a, lr, j));
            chk("op_busy", 8'(bus.busy), 8'(j < n));
            chk("op_done", 8'(bus.done), 8'(j == n));
            if (j == rst_j) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_y", bus.y, 8'h00);
                chk("rst_busy", 8'(bus.busy), 8'h00);
                chk("rst_done", 8'(bus.done), 8'h00);
                for (int k = 0; k < n + 2; k++) begin
                    tick();
                    chk("rst_hold_y", bus.y, 8'h00);
                    chk("rst_hold_done", 8'(bus.done), 8'h00);
                end
                rst = 1'b0;
                return;
            end
            if (j == intr_j) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.lr    = 1'($urandom);
                bus.n     = 3'($urandom);
            end
            if (j < n) begin
                tick();
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic       rlr;
        int         rn;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.lr    = 1'b0;
        bus.n     = 3'd0;

        tick();
        chk("reset_y", bus.y, 8'h00);
        chk("reset_busy", 8'(bus.busy), 8'h00);
        chk("reset_done", 8'(bus.done), 8'h00);
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        tick();
        chk("reset_ignores_start", bus.y, 8'h00);
        bus.start = 1'b0;
        rst       = 1'b0;

        // Directed scenarios
        run_op(8'b10010110, 1'b1, 1, -1, -1);
        chk("dir_left1", bus.y, 8'b00101100);
        idle_hold(8'b00101100);
        run_op(8'b10010110, 1'b0, 1, -1, -1);
        chk("dir_right1", bus.y, 8'b01001011);
        idle_hold(8'b01001011);
        run_op(8'b10010110, 1'b1, 3, -1, -1);
        chk("dir_left3", bus.y, 8'b10110000);
        idle_hold(8'b10110000);
        run_op(8'b10010110, 1'b0, 0, -1, -1);
        chk("dir_n0", bus.y, 8'b10010110);
        idle_hold(8'b10010110);
        run_op(8'b10010110, 1'b0, 7, 2, -1);
        chk("dir_ignore_start", bus.y, 8'b00000001);
        idle_hold(8'b00000001);
        run_op(8'b10010110, 1'b1, 5, -1, 2);
        run_op(8'b10010110, 1'b1, 2, -1, -1);
        chk("dir_after_rst", bus.y, 8'b01011000);

        // Back-to-back directly from DONE
        run_op(8'hC3, 1'b0, 0, -1, -1);
        run_op(8'h81, 1'b1, 1, -1, -1);
        chk("b2b", bus.y, 8'h02);
        idle_hold(8'h02);

        // Random operations, sometimes back-to-back
        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom);
            rlr = 1'($urandom);
            rn  = int'($urandom_range(0, 7));
            run_op(ra, rlr, rn, -1, -1);
            if ($urandom_range(0, 1) == 1) begin
                idle_hold(ref_shift(ra, rlr, rn));
            end
        end
        idle_hold(ref_shift(ra, rlr, rn));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_seq_8bit
